carfield_domain_seq: RTL and testbench

- Parametrised power-domain sequencer. Drives the per-domain clock enable, reset and isolation for N gateable subdomains (periph, safety island, security island, integer cluster, FP cluster, L2, and future domains).
- Replaces fixed, unordered gating with an ordered power-up/power-down sequence per domain: clock settle, reset hold, isolation handshake with timeout.
- Sits between the Carfield control registers and the per-domain clock gates and reset generators. Exports the debug struct fields `domain_clk` / `domain_rsts_n`.

---
 rtl/carfield_domain_seq.sv | 133 +++++++++++++
 tb/tb_carfield_domain_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/carfield_domain_seq.sv
// Per-domain power sequencer: clock settle, reset release, de-isolation; reverse order with iso-ack timeout on power-down.
// Latency: all outputs registered from next state (Moore, 1 cycle); no backpressure, requests are re-evaluated only in OFF/ACTIVE.
module carfield_domain_seq #(
    parameter int unsigned NumDomains      = 6,
    parameter int unsigned ClkSettleCycles = 4,
    parameter int unsigned RstHoldCycles   = 8,
    parameter int unsigned IsoTimeout      = 256,
    localparam int unsigned MaxCnt0 = (ClkSettleCycles > RstHoldCycles) ? ClkSettleCycles : RstHoldCycles,
    localparam int unsigned MaxCnt  = (MaxCnt0 > IsoTimeout) ? MaxCnt0 : IsoTimeout,
    localparam int unsigned CntWidth = $clog2(MaxCnt + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumDomains-1:0] domain_en_i,
    input  logic [NumDomains-1:0] iso_ack_i,
    input  logic [NumDomains-1:0] err_clr_i,
    output logic [NumDomains-1:0] domain_clk_en_o,
    output logic [NumDomains-1:0] domain_rst_no,
    output logic [NumDomains-1:0] iso_req_o,
    output logic [NumDomains-1:0] active_o,
    output logic [NumDomains-1:0] busy_o,
    output logic [NumDomains-1:0] timeout_err_o
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_CLK_ON   = 3'd1,
        S_RST_REL  = 3'd2,
        S_ACTIVE   = 3'd3,
        S_ISOLATE  = 3'd4,
        S_RST_HOLD = 3'd5
    } state_e;

    localparam logic [CntWidth-1:0] SettleLast = CntWidth'(ClkSettleCycles - 1);
    localparam logic [CntWidth-1:0] HoldLast   = CntWidth'(RstHoldCycles - 1);
    localparam logic [CntWidth-1:0] IsoLast    = CntWidth'(IsoTimeout - 1);

    state_e                state_q [NumDomains];
    state_e                state_d [NumDomains];
    logic   [CntWidth-1:0] cnt_q   [NumDomains];
    logic   [CntWidth-1:0] cnt_d   [NumDomains];

    logic [NumDomains-1:0] clk_en_q, clk_en_d;
    logic [NumDomains-1:0] rst_n_q, rst_n_d;
    logic [NumDomains-1:0] iso_q, iso_d;
    logic [NumDomains-1:0] active_q, active_d;
    logic [NumDomains-1:0] busy_q, busy_d;
    logic [NumDomains-1:0] err_q, err_d;

    always_comb begin
        clk_en_d = '0;
        rst_n_d  = '0;
        iso_d    = '1;
        active_d = '0;
        busy_d   = '0;
        err_d    = err_q & ~err_clr_i;
        for (int i = 0; i < NumDomains; i++) begin
            state_d[i] = state_q[i];
            // Saturating count; every timed state clears it on entry.
            cnt_d[i]   = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + 1'b1;
            case (state_q[i])
                S_OFF: begin
                    if (domain_en_i[i]) begin
                        state_d[i] = S_CLK_ON;
                        cnt_d[i]   = '0;
                    end
                end
                S_CLK_ON: begin
                    if (cnt_q[i] == SettleLast) state_d[i] = S_RST_REL;
                end
                S_RST_REL: state_d[i] = S_ACTIVE;
                S_ACTIVE: begin
                    if (!domain_en_i[i]) begin
                        state_d[i] = S_ISOLATE;
                        cnt_d[i]   = '0;
                    end
                end
                S_ISOLATE: begin
                    if (iso_ack_i[i] || cnt_q[i] == IsoLast) begin
                        state_d[i] = S_RST_HOLD;
                        cnt_d[i]   = '0;
                        if (!iso_ack_i[i]) err_d[i] = 1'b1;
                    end
                end
                S_RST_HOLD: begin
                    if (cnt_q[i] == HoldLast) state_d[i] = S_OFF;
                end
                default: state_d[i] = S_OFF;
            endcase

            clk_en_d[i] = (state_d[i] != S_OFF);
            rst_n_d[i]  = (state_d[i] == S_RST_REL) || (state_d[i] == S_ACTIVE) ||
                          (state_d[i] == S_ISOLATE);
            iso_d[i]    = (state_d[i] != S_ACTIVE);
            active_d[i] = (state_d[i] == S_ACTIVE);
            busy_d[i]   = (state_d[i] != S_OFF) && (state_d[i] != S_ACTIVE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumDomains; i++) begin
                state_q[i] <= S_OFF;
                cnt_q[i]   <= '0;
            end
            clk_en_q <= '0;
            rst_n_q  <= '0;
            iso_q    <= '1;
            active_q <= '0;
            busy_q   <= '0;
            err_q    <= '0;
        end else begin
            for (int i = 0; i < NumDomains; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            clk_en_q <= clk_en_d;
            rst_n_q  <= rst_n_d;
            iso_q    <= iso_d;
            active_q <= active_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign domain_clk_en_o = clk_en_q;
    assign domain_rst_no   = rst_n_q;
    assign iso_req_o       = iso_q;
    assign active_o        = active_q;
    assign busy_o          = busy_q;
    assign timeout_err_o   = err_q;

endmodule

// File: tb/tb_carfield_domain_seq.sv
// Directed bench for carfield_domain_seq with default parameters (6 domains, settle 4, hold 8, timeout 256).
module tb_carfield_domain_seq;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] en, ack, clr;
    logic [N-1:0] clk_en, drst_n, iso, active, busy, err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    carfield_domain_seq dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .domain_en_i     (en),
        .iso_ack_i       (ack),
        .err_clr_i       (clr),
        .domain_clk_en_o (clk_en),
        .domain_rst_no   (drst_n),
        .iso_req_o       (iso),
        .active_o        (active),
        .busy_o          (busy),
        .timeout_err_o   (err)
    );

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bring domain d up from OFF; ACTIVE is reached six cycles later.
    task automatic power_up(input int d);
        en[d] = 1'b1;
        tick(6);
        check("pu_active", 32'(active[d]), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = '0;
        ack   = '0;
        clr   = '0;
        #12;
        check("rst_clk_en", 32'(clk_en), 32'h00);
        check("rst_rst_n",  32'(drst_n), 32'h00);
        check("rst_iso",    32'(iso),    32'h3f);
        check("rst_active", 32'(active), 32'h00);
        check("rst_busy",   32'(busy),   32'h00);
        check("rst_err",    32'(err),    32'h00);
        #4 rst_n = 1'b1;
        tick(2);
        check("idle_clk_en", 32'(clk_en), 32'h00);

        // Power-up of domain 2
        en[2] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("pu2_clk_en", 32'(clk_en[2]), 32'd1);
            check("pu2_rst_n",  32'(drst_n[2]), (c >= 5) ? 32'd1 : 32'd0);
            check("pu2_iso",    32'(iso[2]),    (c >= 6) ? 32'd0 : 32'd1);
            check("pu2_active", 32'(active[2]), (c >= 6) ? 32'd1 : 32'd0);
            check("pu2_busy",   32'(busy[2]),   (c <= 5) ? 32'd1 : 32'd0);
            check("pu2_others", 32'(clk_en & 6'b111011), 32'd0);
        end
        en[2]  = 1'b0;
        ack[2] = 1'b1;
        tick(12);
        ack[2] = 1'b0;
        check("pd2_off", 32'(clk_en), 32'd0);

        // Power-down of domain 0 with ack at cycle 3
        power_up(0);
        en[0] = 1'b0;
        tick();
        check("pd0_iso_c1",  32'(iso[0]),    32'd1);
        check("pd0_busy_c1", 32'(busy[0]),   32'd1);
        check("pd0_act_c1",  32'(active[0]), 32'd0);
        tick(2);
        check("pd0_rst_c3", 32'(drst_n[0]), 32'd1);
        ack[0] = 1'b1;
        tick();
        check("pd0_rst_c4", 32'(drst_n[0]), 32'd0);
        check("pd0_clk_c4", 32'(clk_en[0]), 32'd1);
        ack[0] = 1'b0;
        tick(7);
        check("pd0_clk_c11", 32'(clk_en[0]), 32'd1);
        tick();
        check("pd0_clk_c12",  32'(clk_en[0]), 32'd0);
        check("pd0_busy_c12", 32'(busy[0]),   32'd0);
        check("pd0_err",      32'(err[0]),    32'd0);

        // Isolation timeout on domain 0
        power_up(0);
        en[0] = 1'b0;
        tick(256);
        check("to_iso_c256", 32'(iso[0]),    32'd1);
        check("to_rst_c256", 32'(drst_n[0]), 32'd1);
        check("to_err_c256", 32'(err[0]),    32'd0);
        tick();
        check("to_rst_c257", 32'(drst_n[0]), 32'd0);
        check("to_err_c257", 32'(err[0]),    32'd1);
        check("to_busy_c257", 32'(busy[0]),  32'd1);
        tick(8);
        check("to_off_clk", 32'(clk_en[0]), 32'd0);
        check("to_err_off", 32'(err[0]),    32'd1);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        check("to_err_clr", 32'(err[0]), 32'd0);

        // Timeout and clear in the same cycle: set wins
        power_up(0);
        en[0] = 1'b0;
        tick(256);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        check("to_set_wins", 32'(err[0]), 32'd1);
        tick(8);
        check("to2_off", 32'(clk_en[0]), 32'd0);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        check("to2_err_clr", 32'(err[0]), 32'd0);

        // Enable glitch on domain 1: power-up completes, then powers down
        en[1] = 1'b1;
        tick(2);
        en[1] = 1'b0;
        tick(4);
        check("gl_active_c6", 32'(active[1]), 32'd1);
        check("gl_iso_c6",    32'(iso[1]),    32'd0);
        tick();
        check("gl_iso_c7",    32'(iso[1]),    32'd1);
        check("gl_busy_c7",   32'(busy[1]),   32'd1);
        check("gl_active_c7", 32'(active[1]), 32'd0);
        ack[1] = 1'b1;
        tick(9);
        ack[1] = 1'b0;
        check("gl_off_clk",  32'(clk_en[1]), 32'd0);
        check("gl_off_busy", 32'(busy[1]),   32'd0);

        // Async reset while domain 4 is in RST_HOLD
        power_up(4);
        en[4]  = 1'b0;
        ack[4] = 1'b1;
        tick(2);
        check("ar_hold_rst", 32'(drst_n[4]), 32'd0);
        check("ar_hold_clk", 32'(clk_en[4]), 32'd1);
        ack[4] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_clk_en", 32'(clk_en), 32'h00);
        check("ar_rst_n",  32'(drst_n), 32'h00);
        check("ar_iso",    32'(iso),    32'h3f);
        check("ar_busy",   32'(busy),   32'h00);
        rst_n = 1'b1;
        en[4] = 1'b1;
        tick();
        check("ar_restart_clk", 32'(clk_en[4]), 32'd1);
        check("ar_restart_rst", 32'(drst_n[4]), 32'd0);
        tick(5);
        check("ar_restart_act", 32'(active[4]), 32'd1);
        en[4]  = 1'b0;
        ack[4] = 1'b1;
        tick(12);
        ack[4] = 1'b0;
        check("ar_down", 32'(clk_en), 32'h00);

        // All domains in parallel
        en = '1;
        tick(5);
        check("par_act_c5", 32'(active), 32'h00);
        check("par_rst_c5", 32'(drst_n), 32'h3f);
        tick();
        check("par_act_c6",  32'(active), 32'h3f);
        check("par_iso_c6",  32'(iso),    32'h00);
        check("par_busy_c6", 32'(busy),   32'h00);
        check("par_err",     32'(err),    32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
